// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge filter over raster-order gray pixels.
// One registered output stage, two line buffers, per-frame latched mode/threshold.
module sobel_stream #(
  parameter int WIDTH_P  = 8,
  parameter int LINE_W_P = 640,
  parameter int LINE_H_P = 480
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [WIDTH_P-1:0] data_i,
  input  logic               sof_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [1:0]         mode_i,
  input  logic [WIDTH_P-1:0] thresh_i,
  output logic [WIDTH_P-1:0] data_o,
  output logic               sof_o,
  output logic               eol_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               frame_done_o
);

  localparam int CW = $clog2(LINE_W_P);
  localparam int RW = $clog2(LINE_H_P);
  localparam int GW = WIDTH_P + 4;
  localparam logic [WIDTH_P-1:0] PIX_MAX = '1;

  logic [CW-1:0] col_q, cur_col, col_n;
  logic [RW-1:0] row_q, cur_row, row_n;
  logic          col_last, row_last, last_q;
  logic [1:0]    mode_q, eff_mode;
  logic [WIDTH_P-1:0] thresh_q, eff_thresh;
  logic          accept_in, accept_out;

  logic [WIDTH_P-1:0] lb0 [LINE_W_P];  // row-2
  logic [WIDTH_P-1:0] lb1 [LINE_W_P];  // row-1
  logic [WIDTH_P-1:0] win [3][3];
  logic [WIDTH_P-1:0] nw  [3][3];

  logic [GW-1:0]      gx, gy, ax, ay, sum;
  logic [WIDTH_P-1:0] mag, result;

  assign ready_o    = !valid_o || ready_i;
  assign accept_in  = valid_i && ready_o;
  assign accept_out = valid_o && ready_i;

  // A flagged start-of-frame pixel is (0,0) whatever the counters say.
  assign cur_col    = sof_i ? '0 : col_q;
  assign cur_row    = sof_i ? '0 : row_q;
  assign col_last   = (cur_col == CW'(LINE_W_P - 1));
  assign row_last   = (cur_row == RW'(LINE_H_P - 1));
  assign col_n      = col_last ? '0 : cur_col + CW'(1);
  assign row_n      = !col_last ? cur_row : (row_last ? '0 : cur_row + RW'(1));
  assign eff_mode   = sof_i ? mode_i   : mode_q;
  assign eff_thresh = sof_i ? thresh_i : thresh_q;

  function automatic logic [WIDTH_P-1:0] sat(input logic [GW-1:0] v);
    return (v > GW'(PIX_MAX)) ? PIX_MAX : v[WIDTH_P-1:0];
  endfunction

  function automatic logic [GW-1:0] ext(input logic [WIDTH_P-1:0] v);
    return GW'(v);
  endfunction

  // Window as it will look once the current pixel is shifted in.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      nw[r][0] = win[r][1];
      nw[r][1] = win[r][2];
    end
    nw[0][2] = lb0[cur_col];
    nw[1][2] = lb1[cur_col];
    nw[2][2] = data_i;
  end

  // Two's-complement arithmetic in GW bits; |gx|,|gy| <= 4*max always fit.
  always_comb begin
    gx  = (ext(nw[0][2]) + (ext(nw[1][2]) << 1) + ext(nw[2][2]))
        - (ext(nw[0][0]) + (ext(nw[1][0]) << 1) + ext(nw[2][0]));
    gy  = (ext(nw[2][0]) + (ext(nw[2][1]) << 1) + ext(nw[2][2]))
        - (ext(nw[0][0]) + (ext(nw[0][1]) << 1) + ext(nw[0][2]));
    ax  = gx[GW-1] ? -gx : gx;
    ay  = gy[GW-1] ? -gy : gy;
    sum = ax + ay;
    mag = sat(sum);
  end

  // NOTE: every path assigns result first, so no latch is inferred.
  always_comb begin
    result = '0;
    case (eff_mode)
      2'd0:    result = mag;
      2'd1:    result = (mag >= eff_thresh) ? PIX_MAX : '0;
      2'd2:    result = sat(ax);
      default: result = sat(ay);
    endcase
    if (cur_row < RW'(2) || cur_col < CW'(2)) result = '0;
  end

  // NOTE: line buffers and window have no reset; border suppression hides stale data.
  always_ff @(posedge clk_i) begin
    if (accept_in) begin
      lb0[cur_col] <= lb1[cur_col];
      lb1[cur_col] <= data_i;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= nw[r][c];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      col_q        <= '0;
      row_q        <= '0;
      mode_q       <= '0;
      thresh_q     <= '0;
      valid_o      <= 1'b0;
      data_o       <= '0;
      sof_o        <= 1'b0;
      eol_o        <= 1'b0;
      last_q       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= accept_out && last_q;
      if (accept_in) begin
        col_q   <= col_n;
        row_q   <= row_n;
        if (sof_i) begin
          mode_q   <= mode_i;
          thresh_q <= thresh_i;
        end
        valid_o <= 1'b1;
        data_o  <= result;
        sof_o   <= (cur_row == '0) && (cur_col == '0);
        eol_o   <= col_last;
        last_q  <= col_last && row_last;
      end else if (accept_out) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
